ual_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU. Same two-level mode scheme: M=1 logic, M=0 arithmetic.
- Width is generic. Adds a valid/ready handshake on both sides, a status flag set and a multi-cycle shift-add multiplier.
- Sits between the operand register file and the writeback stage of the datapath, as a one-entry pipelined ALU.

---
 rtl/ual_pkg.sv | 28 ++
 rtl/ual_seq_if.sv | 33 +++
 rtl/ual_seq_mul.sv | 49 ++++
 rtl/ual_seq.sv | 190 +++++++++++++++++++
 tb/tb_ual_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ual_pkg.sv
// ual_pkg -- shared opcodes, FSM state and status-flag bundle for ual_seq.
package ual_pkg;

  // Arithmetic-mode function codes (M=0); 9..15 are illegal.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_ASR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic c_out;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/ual_seq_if.sv
// ual_seq_if -- operation/result handshake bundle between producer, ALU and consumer.
interface ual_seq_if #(
  parameter int W = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic         M;
  logic [3:0]   operatie;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic [W-1:0] f_hi;
  logic         c_out;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         err;

  // ALU side.
  modport slave (
    input  in_valid, M, operatie, A, B, c_in, out_ready,
    output in_ready, out_valid, f, f_hi, c_out, zero, neg, ovf, err
  );

  // Producer/consumer side.
  modport master (
    output in_valid, M, operatie, A, B, c_in, out_ready,
    input  in_ready, out_valid, f, f_hi, c_out, zero, neg, ovf, err
  );
endinterface

// File: rtl/ual_seq_mul.sv
// ual_seq_mul -- iterative unsigned shift-add multiplier, one partial product per cycle.
// i_start loads the operands; each i_step cycle adds one partial product.
// o_done flags the step that completes the product, and o_prod already holds
// that final sum so the caller can register it on the same edge.
module ual_seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);
  localparam int CW = $clog2(W);

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = i_step && (r_cnt == CW'(W - 1));
  assign o_prod     = w_acc_next;

  // Operand load on start, one shift-add step per busy cycle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ual_seq.sv
// ual_seq -- registered one-entry ALU with valid/ready handshake and status flags.
// Optional multi-cycle multiplier (operatie=8, M=0) built when UAL_SEQ_MUL_EN is defined;
// otherwise operatie=8 is illegal and f_hi is tied to zero.
module ual_seq
  import ual_pkg::*;
#(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  ual_seq_if.slave   bus
);
  localparam int SHW = $clog2(W);

  logic         r_out_valid;
  logic [W-1:0] r_f;
  flags_t       r_flags;

  logic         w_busy;
  logic         w_is_mul;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_consume;

  logic [W-1:0] w_opb;
  logic         w_cin;
  logic [W:0]   w_sum;
  logic         w_ovf;
  logic [SHW-1:0] w_sh;
  logic [W:0]   w_shl;
  logic [W:0]   w_shr;
  logic [W:0]   w_asr;
  logic [W-1:0] w_core_f;
  flags_t       w_core_flags;

  assign w_in_ready = !w_busy && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = r_out_valid && bus.out_ready;

`ifdef UAL_SEQ_MUL_EN
  state_t         r_state;
  state_t         w_state_next;
  logic           w_mul_done;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   r_f_hi;

  assign w_is_mul = !bus.M && (bus.operatie == OP_MUL);
  assign w_busy   = (r_state == ST_MUL);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state: enter MUL on an accepted multiply, leave on the final step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mul) w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_done)           w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  ual_seq_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_mul),
    .i_step  (w_busy),
    .i_a     (bus.A),
    .i_b     (bus.B),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  assign bus.f_hi = r_f_hi;
`else
  assign w_is_mul = 1'b0;
  assign w_busy   = 1'b0;
  assign bus.f_hi = '0;
`endif

  // Effective addend and carry-in for the adder-based ops.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_opb = bus.B;
    w_cin = 1'b0;
    case (bus.operatie)
      OP_ADD: w_cin = bus.c_in;
      OP_SUB: begin w_opb = ~bus.B; w_cin = bus.c_in; end
      OP_INC: begin w_opb = '0;     w_cin = 1'b1;     end
      OP_DEC: w_opb = '1;
      OP_CMP: begin w_opb = ~bus.B; w_cin = 1'b1;     end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, bus.A} + {1'b0, w_opb} + {{W{1'b0}}, w_cin};
  assign w_ovf = (bus.A[W-1] == w_opb[W-1]) && (w_sum[W-1] != bus.A[W-1]);

  // Shifts carry one guard bit so the last bit shifted out falls into bit W / bit 0;
  // an amount of 0 leaves the guard bit at 0.
  assign w_sh  = bus.B[SHW-1:0];
  assign w_shl = {1'b0, bus.A} << w_sh;
  assign w_shr = {bus.A, 1'b0} >> w_sh;
  assign w_asr = $signed({bus.A, 1'b0}) >>> w_sh;

  // Single-cycle result and flags for both modes.
  always_comb begin
    w_core_f     = '0;
    w_core_flags = '0;
    if (bus.M) begin
      for (int i = 0; i < W; i++) w_core_f[i] = bus.operatie[{bus.A[i], bus.B[i]}];
      w_core_flags.zero = (w_core_f == '0);
      w_core_flags.neg  = w_core_f[W-1];
    end else begin
      case (bus.operatie)
        OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
          w_core_f           = w_sum[W-1:0];
          w_core_flags.c_out = w_sum[W];
          w_core_flags.ovf   = w_ovf;
        end
        OP_SHL: begin w_core_f = w_shl[W-1:0]; w_core_flags.c_out = w_shl[W]; end
        OP_SHR: begin w_core_f = w_shr[W:1];   w_core_flags.c_out = w_shr[0]; end
        OP_ASR: begin w_core_f = w_asr[W:1];   w_core_flags.c_out = w_asr[0]; end
        OP_CMP: begin
          w_core_f           = bus.A;
          w_core_flags.c_out = w_sum[W];
          w_core_flags.ovf   = w_ovf;
        end
        default: w_core_flags.err = 1'b1;
      endcase
      // CMP reports zero/neg of the difference A-B; every other op reports them on f.
      if (!w_core_flags.err) begin
        if (bus.operatie == OP_CMP) begin
          w_core_flags.zero = (w_sum[W-1:0] == '0);
          w_core_flags.neg  = w_sum[W-1];
        end else begin
          w_core_flags.zero = (w_core_f == '0);
          w_core_flags.neg  = w_core_f[W-1];
        end
      end
    end
  end

  // Output register: capture on accept or multiply completion, drop valid on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_flags     <= '0;
`ifdef UAL_SEQ_MUL_EN
      r_f_hi      <= '0;
`endif
    end else begin
`ifdef UAL_SEQ_MUL_EN
      if (w_mul_done) begin
        r_out_valid   <= 1'b1;
        r_f           <= w_prod[W-1:0];
        r_f_hi        <= w_prod[2*W-1:W];
        r_flags.c_out <= |w_prod[2*W-1:W];
        r_flags.zero  <= (w_prod == '0);
        r_flags.neg   <= w_prod[W-1];
        r_flags.ovf   <= 1'b0;
        r_flags.err   <= 1'b0;
      end else
`endif
      if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_f         <= w_core_f;
        r_flags     <= w_core_flags;
`ifdef UAL_SEQ_MUL_EN
        r_f_hi      <= '0;
`endif
      end else if (w_accept || w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.f         = r_f;
  assign bus.c_out     = r_flags.c_out;
  assign bus.zero      = r_flags.zero;
  assign bus.neg       = r_flags.neg;
  assign bus.ovf       = r_flags.ovf;
  assign bus.err       = r_flags.err;
endmodule

// File: tb/tb_ual_seq.sv
// tb_ual_seq -- directed vectors with a scoreboard queue and a decoupled output monitor.
module tb_ual_seq;
  import ual_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] f;
    logic [W-1:0] f_hi;
    flags_t       fl;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   q_exp[$];
  string  q_name[$];
  exp_t   m_e;
  string  m_nm;
  logic   seen;
  int     waited;

  ual_seq_if #(.W(W)) bus ();

  ual_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer (out_valid & out_ready before a rising edge) pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got f=%0h, expected no result", bus.f);
      end else begin
        m_e  = q_exp.pop_front();
        m_nm = q_name.pop_front();
        check({m_nm, ".f"},     bus.f,    m_e.f);
        check({m_nm, ".f_hi"},  bus.f_hi, m_e.f_hi);
        check({m_nm, ".flags"}, {bus.c_out, bus.zero, bus.neg, bus.ovf, bus.err}, m_e.fl);
      end
    end
  end

  // Flags are given as {c_out, zero, neg, ovf, err}.
  task automatic send(input string name, input logic m, input logic [3:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W-1:0] ef, input logic [W-1:0] efh,
                      input flags_t efl, input int elat);
    int   wt;
    int   lat;
    exp_t e;
    @(posedge clk);
    #1;
    bus.M        = m;
    bus.operatie = op;
    bus.A        = a;
    bus.B        = b;
    bus.c_in     = cin;
    bus.in_valid = 1'b1;
    wt = 0;
    do begin
      @(negedge clk);
      wt++;
    end while (!bus.in_ready && wt < 20);
    if (!bus.in_ready) begin
      check({name, ".accept"}, bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      return;
    end
    e.f    = ef;
    e.f_hi = efh;
    e.fl   = efl;
    q_exp.push_back(e);
    q_name.push_back(name);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    check({name, ".latency"}, lat, elat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.M         = 1'b0;
    bus.operatie  = 4'd0;
    bus.A         = '0;
    bus.B         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    #2;
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.f",         bus.f,         8'h00);
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.in_ready",  bus.in_ready,  1'b1);
    check("post_rst.out_valid", bus.out_valid, 1'b0);
    check("post_rst.f_hi",      bus.f_hi,      8'h00);
    check("post_rst.flags", {bus.c_out, bus.zero, bus.neg, bus.ovf, bus.err}, 5'b00000);

    // Arithmetic and logic vectors (flags {c_out, zero, neg, ovf, err}).
    send("add",         1'b0, OP_ADD,  8'd200, 8'd100, 1'b0, 8'h2C, 8'h00, 5'b10000, 1);
    send("sub_neg",     1'b0, OP_SUB,  8'd3,   8'd5,   1'b1, 8'hFE, 8'h00, 5'b00100, 1);
    send("sub_ovf",     1'b0, OP_SUB,  8'h80,  8'h01,  1'b1, 8'h7F, 8'h00, 5'b10010, 1);
    send("lg_xor",      1'b1, 4'b0110, 8'd3,   8'd5,   1'b0, 8'h06, 8'h00, 5'b00000, 1);
    send("lg_and",      1'b1, 4'b1000, 8'd3,   8'd5,   1'b0, 8'h01, 8'h00, 5'b00000, 1);
    send("lg_zero",     1'b1, 4'b0000, 8'd3,   8'd5,   1'b0, 8'h00, 8'h00, 5'b01000, 1);
    send("add_cin_ovf", 1'b0, OP_ADD,  8'h7F,  8'h00,  1'b1, 8'h80, 8'h00, 5'b00110, 1);
    send("inc_wrap",    1'b0, OP_INC,  8'hFF,  8'h5A,  1'b1, 8'h00, 8'h00, 5'b11000, 1);
    send("dec_zero",    1'b0, OP_DEC,  8'h00,  8'h33,  1'b1, 8'hFF, 8'h00, 5'b00100, 1);
    send("dec_ovf",     1'b0, OP_DEC,  8'h80,  8'h00,  1'b0, 8'h7F, 8'h00, 5'b10010, 1);
    send("shl1",        1'b0, OP_SHL,  8'h81,  8'h01,  1'b0, 8'h02, 8'h00, 5'b10000, 1);
    send("shl_amt0",    1'b0, OP_SHL,  8'h81,  8'h10,  1'b0, 8'h81, 8'h00, 5'b00100, 1);
    send("shr1",        1'b0, OP_SHR,  8'h05,  8'h01,  1'b0, 8'h02, 8'h00, 5'b10000, 1);
    send("shr7",        1'b0, OP_SHR,  8'h80,  8'h07,  1'b0, 8'h01, 8'h00, 5'b00000, 1);
    send("asr2",        1'b0, OP_ASR,  8'h86,  8'h02,  1'b0, 8'hE1, 8'h00, 5'b10100, 1);
    send("cmp",         1'b0, OP_CMP,  8'h05,  8'h03,  1'b0, 8'h05, 8'h00, 5'b10000, 1);
    send("ill9",        1'b0, 4'd9,    8'h12,  8'h34,  1'b0, 8'h00, 8'h00, 5'b00001, 1);
    send("ill15",       1'b0, 4'd15,   8'hFF,  8'hFF,  1'b1, 8'h00, 8'h00, 5'b00001, 1);
`ifdef UAL_SEQ_MUL_EN
    send("mul_13x11",   1'b0, OP_MUL,  8'd13,  8'd11,  1'b0, 8'h8F, 8'h00, 5'b00100, W);
    send("mul_ffxff",   1'b0, OP_MUL,  8'hFF,  8'hFF,  1'b0, 8'h01, 8'hFE, 5'b10000, W);
    send("mul_x0",      1'b0, OP_MUL,  8'h5A,  8'h00,  1'b0, 8'h00, 8'h00, 5'b01000, W);
    send("mul_x1",      1'b0, OP_MUL,  8'h9A,  8'h01,  1'b0, 8'h9A, 8'h00, 5'b00100, W);
`else
    send("mul_off",     1'b0, OP_MUL,  8'd13,  8'd11,  1'b0, 8'h00, 8'h00, 5'b00001, 1);
`endif
    send("add_after",   1'b0, OP_ADD,  8'h01,  8'h01,  1'b0, 8'h02, 8'h00, 5'b00000, 1);

    // Back-pressure: result held while out_ready=0, next op accepted on the consume edge.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send("hold_a", 1'b0, OP_ADD, 8'd10, 8'd20, 1'b0, 8'h1E, 8'h00, 5'b00000, 1);
    fork
      send("hold_b", 1'b1, 4'b0110, 8'hF0, 8'hFF, 1'b0, 8'h0F, 8'h00, 5'b00000, 1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("hold.in_ready",  bus.in_ready,  1'b0);
          check("hold.out_valid", bus.out_valid, 1'b1);
          check("hold.f",         bus.f,         8'h1E);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join

    // Reset while busy (mid-multiply, or holding a result when the multiplier is absent).
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.M         = 1'b0;
`ifdef UAL_SEQ_MUL_EN
    bus.operatie  = OP_MUL;
`else
    bus.operatie  = OP_ADD;
`endif
    bus.A         = 8'd13;
    bus.B         = 8'd11;
    bus.c_in      = 1'b0;
    bus.in_valid  = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < 20);
    check("rstmid.accept", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("rstmid.busy_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", bus.out_valid, 1'b0);
    check("rstmid.f",         bus.f,         8'h00);
    check("rstmid.f_hi",      bus.f_hi,      8'h00);
    check("rstmid.flags", {bus.c_out, bus.zero, bus.neg, bus.ovf, bus.err}, 5'b00000);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid.in_ready_after", bus.in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("rstmid.no_stale", seen, 1'b0);
    bus.out_ready = 1'b1;

    send("post_rstmid", 1'b0, OP_SUB, 8'd9, 8'd4, 1'b1, 8'h05, 8'h00, 5'b10000, 1);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
